key_pad: RTL and testbench

- Parametrised successor to the raw 8-bit key input port: a memory-mapped key peripheral with per-key synchronisation, debounce, press-event latching, masking and an interrupt request.
- Sits on the bridge/device bus next to the timer.
- CPU reads the debounced key state and latched press events through a registered read port, and clears events with write-1-to-clear.
- IRQ goes to the CP0 hardware-interrupt input.

---
 rtl/key_pad_pkg.sv | 13 +
 rtl/key_pad_if.sv | 18 +
 rtl/key_debounce.sv | 70 +++++++
 rtl/key_pad.sv | 136 +++++++++++++
 tb/tb_key_pad.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/key_pad_pkg.sv
// key_pad_pkg: shared constants for the key peripheral.
//   - register word offsets (bus byte address bits [3:2])
//   - default debounce length for a real system clock
package key_pad_pkg;

  localparam logic [1:0] KP_STATE   = 2'd0;
  localparam logic [1:0] KP_PEND    = 2'd1;
  localparam logic [1:0] KP_MASK    = 2'd2;
  localparam logic [1:0] KP_RELPEND = 2'd3;

  localparam int unsigned KP_DEBOUNCE_CYCLES_DEF = 20000;

endpackage

// File: rtl/key_pad_if.sv
// key_pad_if: device-bus connection of the key peripheral.
//   addr  word select           (master -> slave)
//   we    one-cycle write strobe (master -> slave)
//   wd    write data             (master -> slave)
//   RD    registered read data   (slave -> master)
//   irq   level interrupt        (slave -> master)
interface key_pad_if;

  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] RD;
  logic        irq;

  modport master (output addr, output we, output wd, input RD, input irq);
  modport slave  (input addr, input we, input wd, output RD, output irq);

endinterface

// File: rtl/key_debounce.sv
// key_debounce: one key channel.
//   clk, reset_n   system clock, async active-low reset
//   raw_n          raw pin, active-low, asynchronous to clk
//   stable         debounced state, 1 = pressed
//   rise / fall    one-cycle pulses on the same edge stable goes 0->1 / 1->0
// The synchroniser runs on the raw (active-low) polarity so its reset value
// of all ones means "released"; the inversion happens after the last stage.
module key_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_n,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_pressed;

  assign sync_pressed = ~sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '1;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_n};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  // Any sample that agrees with the stable state restarts the count, so
  // only DEBOUNCE_CYCLES consecutive disagreeing samples flip the state.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync_pressed != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_pressed;
        rise_d   = sync_pressed;
        fall_d   = ~sync_pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/key_pad.sv
// key_pad: memory-mapped key peripheral.
//   clk        system clock
//   reset_n    async active-low reset
//   user_key   raw key pins, active-low, asynchronous
//   bus        key_pad_if.slave (addr, we, wd, RD, irq)
// Registers: 0 STATE (ro), 1 PEND (W1C), 2 MASK (rw), 3 RELPEND.
// Optional build macro KEY_PAD_RELEASE_EVT_EN adds release events in RELPEND
// and release enables in MASK[N_KEYS+15:16]; it needs N_KEYS <= 16.
// Without it addr 3 reads 0 and the upper MASK bits read 0.
module key_pad
  import key_pad_pkg::*;
#(
  parameter int unsigned N_KEYS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] user_key,
  key_pad_if.slave          bus
);

  logic [N_KEYS-1:0] stable_w, rise_w, fall_w;
  logic [N_KEYS-1:0] pend_q, pend_d;
  logic [N_KEYS-1:0] mask_lo_q, mask_lo_d;
  logic [31:0]       rd_q, rd_d;
  logic              irq_q, irq_d;
  logic              wr_pend, wr_mask;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_n   (user_key[i]),
      .stable  (stable_w[i]),
      .rise    (rise_w[i]),
      .fall    (fall_w[i])
    );
  end

  assign wr_pend = bus.we && (bus.addr == KP_PEND);
  assign wr_mask = bus.we && (bus.addr == KP_MASK);

  // Clear first, then OR in new events: a same-cycle event beats the W1C.
  always_comb begin
    pend_d = pend_q;
    if (wr_pend) pend_d = pend_d & ~bus.wd[N_KEYS-1:0];
    pend_d = pend_d | rise_w;
  end

  always_comb begin
    mask_lo_d = mask_lo_q;
    if (wr_mask) mask_lo_d = bus.wd[N_KEYS-1:0];
  end

`ifdef KEY_PAD_RELEASE_EVT_EN
  logic [N_KEYS-1:0] relpend_q, relpend_d;
  logic [N_KEYS-1:0] mask_hi_q, mask_hi_d;
  logic              wr_relpend;

  assign wr_relpend = bus.we && (bus.addr == KP_RELPEND);

  always_comb begin
    relpend_d = relpend_q;
    if (wr_relpend) relpend_d = relpend_d & ~bus.wd[N_KEYS-1:0];
    relpend_d = relpend_d | fall_w;
  end

  always_comb begin
    mask_hi_d = mask_hi_q;
    if (wr_mask) mask_hi_d = bus.wd[16 +: N_KEYS];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      relpend_q <= '0;
      mask_hi_q <= '0;
    end else begin
      relpend_q <= relpend_d;
      mask_hi_q <= mask_hi_d;
    end
  end

  assign irq_d = (|(pend_q & mask_lo_q)) | (|(relpend_q & mask_hi_q));
`else
  assign irq_d = |(pend_q & mask_lo_q);
`endif

  always_comb begin
    rd_d = '0;
    case (bus.addr)
      KP_STATE: rd_d[N_KEYS-1:0] = stable_w;
      KP_PEND:  rd_d[N_KEYS-1:0] = pend_q;
      KP_MASK: begin
        rd_d[N_KEYS-1:0] = mask_lo_q;
`ifdef KEY_PAD_RELEASE_EVT_EN
        rd_d[16 +: N_KEYS] = mask_hi_q;
`endif
      end
`ifdef KEY_PAD_RELEASE_EVT_EN
      KP_RELPEND: rd_d[N_KEYS-1:0] = relpend_q;
`endif
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q    <= '0;
      mask_lo_q <= '0;
      rd_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      mask_lo_q <= mask_lo_d;
      rd_q      <= rd_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.RD  = rd_q;
  assign bus.irq = irq_q;

  // Write-data bits beyond the implemented registers, and release pulses
  // when release events are not built in, are intentionally dropped.
  logic unused_sig;
`ifdef KEY_PAD_RELEASE_EVT_EN
  assign unused_sig = ^bus.wd;
`else
  assign unused_sig = ^{bus.wd, fall_w};
`endif

endmodule

// File: tb/tb_key_pad.sv
module tb_key_pad;
  import key_pad_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] user_key = 8'hFF;

  int n_checks = 0;
  int n_fail   = 0;

  key_pad_if bus ();

  key_pad #(
    .N_KEYS          (8),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .user_key (user_key),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.wd   = d;
    bus.we   = 1'b1;
    tick();
    bus.we   = 1'b0;
    bus.wd   = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    tick();
    chk(tag, bus.RD, exp);
  endtask

  initial begin
    bus.addr = KP_STATE;
    bus.we   = 1'b0;
    bus.wd   = '0;

    // Reset with key 0 held.
    user_key = 8'hFE;
    tick(3);
    reset_n = 1'b1;
    chk("rst_rd", bus.RD, 32'h0);
    chk("rst_irq", {31'b0, bus.irq}, 32'h0);
    // Stable flips on the 6th edge after release; RD shows it on the 7th.
    tick(6);
    chk("rst_state_early", bus.RD, 32'h0);
    tick();
    chk("rst_state", bus.RD, 32'h1);
    rd_chk("rst_pend", KP_PEND, 32'h1);

    // Release key 0 and clear its events.
    user_key = 8'hFF;
    tick(10);
    wr(KP_PEND, 32'h1);
`ifdef KEY_PAD_RELEASE_EVT_EN
    wr(KP_RELPEND, 32'h1);
`endif
    rd_chk("pend_cleared", KP_PEND, 32'h0);

    // Glitch of 3 cycles on key 3 is rejected.
    user_key[3] = 1'b0;
    tick(3);
    user_key[3] = 1'b1;
    tick(10);
    rd_chk("glitch_state", KP_STATE, 32'h0);
    rd_chk("glitch_pend", KP_PEND, 32'h0);

    // Long press on key 3.
    user_key[3] = 1'b0;
    tick(10);
    rd_chk("press_state", KP_STATE, 32'h8);
    rd_chk("press_pend", KP_PEND, 32'h8);
    wr(KP_PEND, 32'h8);
    tick(8);
    rd_chk("one_event", KP_PEND, 32'h0);

    // Bounce on key 5: low 2, high 2, then held low.
    user_key[5] = 1'b0;
    tick(2);
    user_key[5] = 1'b1;
    tick(2);
    user_key[5] = 1'b0;
    bus.addr = KP_PEND;
    tick(7);
    chk("bounce_early", bus.RD, 32'h0);
    tick();
    chk("bounce_pend", bus.RD, 32'h20);

    // Re-press key 3 to get PEND[3] back.
    user_key[3] = 1'b1;
    tick(10);
    user_key[3] = 1'b0;
    tick(10);
`ifdef KEY_PAD_RELEASE_EVT_EN
    wr(KP_RELPEND, 32'hFF);
`endif
    rd_chk("pend_3_5", KP_PEND, 32'h28);

    // IRQ path.
    wr(KP_MASK, 32'h08);
    chk("irq_mask_edge", {31'b0, bus.irq}, 32'h0);
    tick();
    chk("irq_set", {31'b0, bus.irq}, 32'h1);
    wr(KP_PEND, 32'h08);
    chk("irq_w1c_edge", {31'b0, bus.irq}, 32'h1);
    tick();
    chk("irq_drop", {31'b0, bus.irq}, 32'h0);
    rd_chk("pend_after_w1c", KP_PEND, 32'h20);
    rd_chk("mask_rd", KP_MASK, 32'h08);
    chk("irq_masked", {31'b0, bus.irq}, 32'h0);

    // Set-wins: W1C of bits 2 and 5 during key 2's rise pulse.
    user_key[2] = 1'b0;
    tick(6);
    wr(KP_PEND, 32'h24);
    rd_chk("set_wins", KP_PEND, 32'h04);

    // STATE is read-only.
    wr(KP_STATE, 32'hFFFF_FFFF);
    rd_chk("state_ro", KP_STATE, 32'h2C);

`ifdef KEY_PAD_RELEASE_EVT_EN
    user_key[3] = 1'b1;
    tick(10);
    rd_chk("relpend", KP_RELPEND, 32'h8);
    wr(KP_MASK, 32'h0008_0000);
    tick();
    chk("rel_irq", {31'b0, bus.irq}, 32'h1);
    rd_chk("mask_hi_rd", KP_MASK, 32'h0008_0000);
    wr(KP_RELPEND, 32'h8);
    tick();
    chk("rel_irq_drop", {31'b0, bus.irq}, 32'h0);
`else
    wr(KP_MASK, 32'hFFFF_FFFF);
    rd_chk("mask_width", KP_MASK, 32'h0000_00FF);
    chk("irq_all_mask", {31'b0, bus.irq}, 32'h1);
    rd_chk("addr3_zero", KP_RELPEND, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
